imsic_msi_arb: RTL and testbench
================================

// Module: imsic_msi_arb
// PURPOSE
//  Arbitrates NUM_REQ imsic_axi2reg front ends (e.g. M-file and S-file MSI ports) that share one imsic_regmap.
//  Drives each front end's msi_recv_vld so only one transaction is in flight at a time.
//  Muxes the granted front end's reg_wr/reg_waddr/reg_wdata onto the single regmap write port.
//  Round-robin, one transaction per grant.
// PARAMETERS
//  NUM_REQ        2   number of front ends, 2..8
//  AXI_ADDR_WIDTH 32  width of reg_waddr
//  TIMEOUT_CYC    256 watchdog limit in cycles; used only with IMSIC_ARB_TIMEOUT_EN
// PORTS
//  clk          in  1            clock
//  rst          in  1            asynchronous, active-high reset
//  req_i        in  NUM_REQ      per front end: awvalid_s|arvalid_s
//  idle_i       in  NUM_REQ      per front end: msi_idle
//  done_i       in  NUM_REQ      per front end: (bvalid_s&bready_s)|(rvalid_s&rready_s)
//  reg_wr_i     in  NUM_REQ      per front end: reg_wr
//  reg_waddr_i  in  NUM_REQ*AW   packed reg_waddr; slot k = [k*AW +: AW]
//  reg_wdata_i  in  NUM_REQ*32   packed reg_wdata; slot k = [k*32 +: 32]
//  recv_vld_o   out NUM_REQ      msi_recv_vld to each front end; one-hot or zero
//  reg_wr_o     out 1            write strobe to imsic_regmap
//  reg_waddr_o  out AW           write address to imsic_regmap
//  reg_wdata_o  out 32           write data to imsic_regmap
//  grant_id_o   out clog2(N)     index of the current or last grant
//  busy_o       out 1            state != ARB_IDLE
//  timeout_o    out 1            one-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset values: state=ARB_IDLE, recv_vld_o=0, grant_id_o=NUM_REQ-1 (so requester 0 wins first), busy_o=0, timeout_o=0.
//  States:
//   ARB_IDLE -> ARB_GRANT when |req_i.
//     Winner = first set req_i bit scanning from grant_id_o+1 upward, wrapping at NUM_REQ.
//     grant_id_o <= winner; recv_vld_o <= onehot(winner), registered, so 1-cycle latency from req to vld.
//   ARB_GRANT holds recv_vld_o until done_i[g].
//     On done_i[g]: recv_vld_o <= 0, state -> ARB_GAP.
//     Withdraw: if req_i[g]=0 && idle_i[g]=1, then recv_vld_o <= 0 and state -> ARB_IDLE (no transaction started).
//   ARB_GAP lasts 1 cycle, then -> ARB_IDLE.
//     Guarantees the front end is back in IDLE_ST with recv_vld low, so it cannot re-trigger on its own grant.
//  Fairness: the requester just served has lowest priority next round. With all requesters continuously active, grants rotate 0,1,..,N-1,0.
//  Only one recv_vld_o bit is ever set. done_i/reg_wr_i bits of non-granted requesters are ignored.
//  Regmap mux is combinational:
//   reg_wr_o = reg_wr_i[g] & (state==ARB_GRANT)
//   reg_waddr_o / reg_wdata_o = slot g, always driven, including when reg_wr_o=0.
//  A done_i[g] in the same cycle as reg_wr_i[g] is legal; the write is still forwarded.
//  Reset mid-transaction: arbiter returns to reset values immediately; front ends are reset by the same domain.
//  NUM_REQ=1: grant is always 0; the FSM is unchanged.
// CONFIGURATION
//  IMSIC_ARB_TIMEOUT_EN defined:
//   A counter clears on entry to ARB_GRANT and increments every cycle in ARB_GRANT.
//   On reaching TIMEOUT_CYC-1 without done/withdraw: recv_vld_o <= 0, timeout_o pulses 1 cycle, state -> ARB_GAP.
//   The stuck requester loses its turn (grant pointer advances as normal).
//  IMSIC_ARB_TIMEOUT_EN undefined: no counter; timeout_o tied 0; ARB_GRANT waits indefinitely.
// TESTING
//  T1 reset: assert rst with req_i=2'b11 -> recv_vld_o=0, busy_o=0; first cycle after release, ARB_IDLE picks 0; next cycle recv_vld_o=2'b01.
//  T2 single write: req_i[1] rises; front end 1 issues reg_wr_i[1], addr 0x0000_1000, data 0x5 -> reg_wr_o=1, addr/data match in the same cycle; done_i[1] -> recv_vld_o=0 next cycle; busy_o drops 2 cycles later.
//  T3 round-robin: req_i=2'b11 held for 4 transactions -> grant order 0,1,0,1; recv_vld_o never 2'b11.
//  T4 withdraw: req_i[0] pulsed 1 cycle, idle_i[0]=1 kept -> recv_vld_o[0] high 1 cycle, then ARB_IDLE; no reg_wr_o.
//  T5 non-granted noise: reg_wr_i[1]=1 and done_i[1]=1 while grant=0 -> reg_wr_o follows only reg_wr_i[0]; state unchanged.
//  T6 timeout (macro on, TIMEOUT_CYC=16): grant 0, done never -> recv_vld_o falls at cycle 16 of ARB_GRANT, timeout_o=1 one cycle; pending req_i[1] granted next.

Source files
------------

// File: rtl/imsic_msi_arb.sv
// imsic_msi_arb: round-robin arbiter that lets NUM_REQ imsic_axi2reg front ends
// share one imsic_regmap write port. Each grant covers exactly one
// transaction.
//
// Optional feature: define IMSIC_ARB_TIMEOUT_EN to add a grant watchdog.
// It releases a grant that has not finished after TIMEOUT_CYC cycles.
// When the macro is undefined, timeout_o is tied low and a grant waits forever.
//
// Handshake: req_i[k] asks for a turn. recv_vld_o[k] is the grant. It is
// registered, so it rises one cycle after the arbiter sees the request.
// The grant stays high until one of these happens:
//   - done_i[k] pulses, meaning the transaction completed;
//   - the requester withdraws (req_i[k]=0 while idle_i[k]=1);
//   - the watchdog fires (only when it is built in).
// After a completed or timed-out transaction, one gap cycle keeps recv_vld low
// so the front end can settle back into its idle state.
module imsic_msi_arb #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 256,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0]               idle_i,
  input  logic [NUM_REQ-1:0]               done_i,
  input  logic [NUM_REQ-1:0]               reg_wr_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [NUM_REQ*32-1:0]            reg_wdata_i,
  output logic [NUM_REQ-1:0]               recv_vld_o,
  output logic                             reg_wr_o,
  output logic [AXI_ADDR_WIDTH-1:0]        reg_waddr_o,
  output logic [31:0]                      reg_wdata_o,
  output logic [GW-1:0]                    grant_id_o,
  output logic                             busy_o,
  output logic                             timeout_o
);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]  vld_q, vld_d;

  logic [GW-1:0]       winner;
  logic                g_req, g_idle, g_done, g_wr;
  logic                withdraw;
  logic                to_fire;
  logic                cnt_hit;

  // Round-robin search: first set request after the last grant, wrapping.
  always_comb begin
    int  idx;
    logic found;
    winner = grant_q;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(grant_q) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  // Select the granted front end's control bits and regmap write slot.
  always_comb begin
    g_req       = req_i[0];
    g_idle      = idle_i[0];
    g_done      = done_i[0];
    g_wr        = reg_wr_i[0];
    reg_waddr_o = reg_waddr_i[0 +: AXI_ADDR_WIDTH];
    reg_wdata_o = reg_wdata_i[0 +: 32];
    for (int k = 1; k < NUM_REQ; k++) begin
      if (grant_q == GW'(k)) begin
        g_req       = req_i[k];
        g_idle      = idle_i[k];
        g_done      = done_i[k];
        g_wr        = reg_wr_i[k];
        reg_waddr_o = reg_waddr_i[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        reg_wdata_o = reg_wdata_i[k*32 +: 32];
      end
    end
  end

  // A withdraw only counts when the front end never started a transaction.
  assign withdraw = !g_req && g_idle;
  assign to_fire  = (state_q == ARB_GRANT) && cnt_hit && !g_done && !withdraw;

`ifdef IMSIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  assign cnt_hit = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // The counter is zero whenever the arbiter is idle, so it always starts
  // from zero on entry to ARB_GRANT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ARB_GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter and the one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= to_fire;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign cnt_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state and grant logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    vld_d   = vld_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          state_d = ARB_GRANT;
          grant_d = winner;
          for (int k = 0; k < NUM_REQ; k++) begin
            vld_d[k] = (winner == GW'(k));
          end
        end
      end
      ARB_GRANT: begin
        if (g_done) begin
          vld_d   = '0;
          state_d = ARB_GAP;
        end else if (withdraw) begin
          vld_d   = '0;
          state_d = ARB_IDLE;
        end else if (to_fire) begin
          vld_d   = '0;
          state_d = ARB_GAP;
        end
      end
      ARB_GAP: begin
        vld_d   = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        vld_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant pointer and registered recv_vld.
  // The pointer resets to NUM_REQ-1 so that requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= GW'(NUM_REQ - 1);
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
    end
  end

  assign recv_vld_o = vld_q;
  assign reg_wr_o   = g_wr && (state_q == ARB_GRANT);
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_imsic_msi_arb.sv
// Testbench for imsic_msi_arb with NUM_REQ=2, driven by directed and random
// transactions. The expected grant comes from a round-robin pointer model.
module tb_imsic_msi_arb;

  localparam int N  = 2;
  localparam int AW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_i, idle_i, done_i, reg_wr_i;
  logic [N*AW-1:0]   reg_waddr_i;
  logic [N*32-1:0]   reg_wdata_i;
  logic [N-1:0]      recv_vld_o;
  logic              reg_wr_o;
  logic [AW-1:0]     reg_waddr_o;
  logic [31:0]       reg_wdata_o;
  logic [0:0]        grant_id_o;
  logic              busy_o;
  logic              timeout_o;

  int n_checks = 0;
  int n_fail   = 0;
  int last_g   = N - 1;
  logic [N-1:0] pend;

  imsic_msi_arb #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .idle_i(idle_i), .done_i(done_i), .reg_wr_i(reg_wr_i),
    .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .recv_vld_o(recv_vld_o), .reg_wr_o(reg_wr_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // Clock and time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampling and driving happen 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference arbitration rule: first requester after the last grant, wrapping.
  function automatic int pick(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last_g + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Runs one complete granted transaction, starting from the arbiter idle.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                     input bit same, input bit noise, input logic [N-1:0] next_pend);
    int w, o, waited;
    w = pick(pend);
    o = (w + 1) % N;
    req_i = pend;
    waited = 0;
    while (recv_vld_o == '0 && waited < 4) begin
      tick();
      waited++;
    end
    chk("grant_latency", waited, 1);
    chk("grant_vld", recv_vld_o, 64'(1) << w);
    chk("grant_id", grant_id_o, w);
    chk("busy_grant", busy_o, 1);
    chk("timeout_idle", timeout_o, 0);
    idle_i[w] = 1'b0;
    reg_wr_i  = '0;
    reg_wr_i[w] = wr;
    reg_waddr_i[w*AW +: AW] = a;
    reg_wdata_i[w*32 +: 32] = d;
    if (noise) begin
      reg_wr_i[o] = 1'b1;
      done_i[o]   = 1'b1;
      reg_waddr_i[o*AW +: AW] = $urandom;
      reg_wdata_i[o*32 +: 32] = $urandom;
    end
    if (same) done_i[w] = 1'b1;
    #1;
    chk("mux_wr", reg_wr_o, wr);
    chk("mux_addr", reg_waddr_o, a);
    chk("mux_data", reg_wdata_o, d);
    if (!same) begin
      tick();
      chk("vld_held", recv_vld_o, 64'(1) << w);
      chk("busy_held", busy_o, 1);
      reg_wr_i[w] = 1'b0;
      done_i[w]   = 1'b1;
      #1;
      chk("mux_wr_off", reg_wr_o, 0);
    end
    req_i = next_pend;
    tick();
    done_i   = '0;
    idle_i   = '1;
    reg_wr_i = '1;
    #1;
    chk("gap_vld", recv_vld_o, 0);
    chk("gap_busy", busy_o, 1);
    chk("gap_grant_id", grant_id_o, w);
    chk("gap_wr_blocked", reg_wr_o, 0);
    reg_wr_i = '0;
    tick();
    chk("idle_busy", busy_o, 0);
    chk("idle_vld", recv_vld_o, 0);
    last_g = w;
    pend   = next_pend;
  endtask

  initial begin
    rst = 1'b1;
    req_i = 2'b11;
    idle_i = '1;
    done_i = '0;
    reg_wr_i = '0;
    reg_waddr_i = '0;
    reg_wdata_i = '0;
    pend = 2'b11;

    // T1: reset with both requests asserted.
    repeat (3) tick();
    chk("rst_vld", recv_vld_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant_id", grant_id_o, N - 1);
    chk("rst_timeout", timeout_o, 0);
    rst = 1'b0;
    txn(1'b1, 32'h0000_0040, 32'h11, 1'b0, 1'b0, 2'b10);

    // T2: single write from requester 1.
    txn(1'b1, 32'h0000_1000, 32'h5, 1'b0, 1'b0, 2'b11);

    // T3: both requesters continuously active; expected order is 0,1,0,1.
    pend = 2'b11;
    txn(1'b1, 32'h0000_0100, 32'hA0, 1'b0, 1'b0, 2'b11);
    txn(1'b1, 32'h0000_0104, 32'hA1, 1'b1, 1'b0, 2'b11);
    txn(1'b0, 32'h0000_0108, 32'hA2, 1'b0, 1'b0, 2'b11);
    txn(1'b1, 32'h0000_010C, 32'hA3, 1'b1, 1'b0, 2'b00);

    // T4: requester 0 withdraws after one cycle without starting.
    req_i = 2'b01;
    tick();
    chk("wd_vld", recv_vld_o, 2'b01);
    chk("wd_grant_id", grant_id_o, 0);
    req_i = 2'b00;
    #1;
    chk("wd_no_wr", reg_wr_o, 0);
    tick();
    chk("wd_vld_off", recv_vld_o, 0);
    chk("wd_busy", busy_o, 0);
    last_g = 0;
    tick();
    chk("wd_stay_idle", busy_o, 0);

    // T5: writes and done from the non-granted requester are ignored.
    pend = 2'b10;
    txn(1'b1, 32'h0000_2000, 32'hBEEF, 1'b0, 1'b1, 2'b00);
    pend = 2'b01;
    txn(1'b0, 32'h0000_2004, 32'hCAFE, 1'b0, 1'b1, 2'b00);

`ifdef IMSIC_ARB_TIMEOUT_EN
    // T6: the granted requester never finishes; the watchdog releases it.
    begin
      int w, o;
      pend = 2'b11;
      req_i = pend;
      w = pick(pend);
      o = (w + 1) % N;
      tick();
      chk("to_vld", recv_vld_o, 64'(1) << w);
      idle_i[w] = 1'b0;
      for (int c = 2; c <= 16; c++) begin
        tick();
        chk("to_vld_hold", recv_vld_o, 64'(1) << w);
        chk("to_no_pulse", timeout_o, 0);
      end
      tick();
      chk("to_vld_off", recv_vld_o, 0);
      chk("to_pulse", timeout_o, 1);
      chk("to_busy_gap", busy_o, 1);
      req_i[w] = 1'b0;
      idle_i[w] = 1'b1;
      tick();
      chk("to_pulse_end", timeout_o, 0);
      chk("to_idle", busy_o, 0);
      last_g = w;
      pend = 2'b00;
      pend[o] = 1'b1;
      txn(1'b1, 32'h0000_3000, 32'h77, 1'b1, 1'b0, 2'b00);
    end
`endif

    // Random transactions.
    for (int t = 0; t < 24; t++) begin
      pend = N'($urandom_range(1, 3));
      txn(1'($urandom_range(0, 1)), $urandom, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          N'($urandom_range(0, 3)));
    end

    // Reset in the middle of a grant takes effect immediately.
    req_i = 2'b11;
    tick();
    chk("mid_vld", recv_vld_o != '0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", recv_vld_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_grant_id", grant_id_o, N - 1);
    req_i = '0;
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
